// File: rtl/gpio_irq_ip.sv
`default_nettype none
// ============================================================================
// Module   : gpio_irq_ip
// Purpose  : N_GPIO-pin GPIO peripheral on the simple wr_en/rd_en register
//            bus. DATA/DIR/IN registers, atomic SET/CLR/TGL writes to DATA,
//            an input synchroniser, and per-pin edge/level interrupts with
//            sticky write-1-to-clear status and one combined irq line.
// Ports    : clk, rst_n (synchronous, active low)
//            wr_en, rd_en, addr[7:0], wdata[31:0] -> register bus requests
//            rdata[31:0], rvalid                  -> registered read response
//            gpio_in                              -> asynchronous pad inputs
//            gpio_out (DATA & DIR), gpio_oe (DIR) -> pad drivers
//            irq                                  -> |(STAT & IRQ_EN)
// Revision : 1.0 - initial release
// ============================================================================
module gpio_irq_ip #(
    parameter int N_GPIO      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [7:0]        addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              rvalid,
    input  logic [N_GPIO-1:0] gpio_in,
    output logic [N_GPIO-1:0] gpio_out,
    output logic [N_GPIO-1:0] gpio_oe,
    output logic              irq
);

    // Word offsets (addr[7:2])
    localparam logic [5:0] c_addr_data  = 6'h00;
    localparam logic [5:0] c_addr_dir   = 6'h01;
    localparam logic [5:0] c_addr_in    = 6'h02;
    localparam logic [5:0] c_addr_set   = 6'h03;
    localparam logic [5:0] c_addr_clr   = 6'h04;
    localparam logic [5:0] c_addr_tgl   = 6'h05;
    localparam logic [5:0] c_addr_en    = 6'h06;
    localparam logic [5:0] c_addr_type  = 6'h07;
    localparam logic [5:0] c_addr_pol   = 6'h08;
    localparam logic [5:0] c_addr_stat  = 6'h09;

    // Warm-up runs until the synchroniser and prev flop hold real pad data.
    localparam logic [2:0] c_warm_last  = 3'(SYNC_STAGES + 1);

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic [N_GPIO-1:0] r_data;
    logic [N_GPIO-1:0] r_dir;
    logic [N_GPIO-1:0] r_irq_en;
    logic [N_GPIO-1:0] r_irq_type;
    logic [N_GPIO-1:0] r_irq_pol;
    logic [N_GPIO-1:0] r_stat;
    logic [N_GPIO-1:0] r_sync [SYNC_STAGES];
    logic [N_GPIO-1:0] r_prev;
    logic [2:0]        r_warm;

    logic [5:0]        w_word;
    logic [N_GPIO-1:0] w_wdata;
    logic [N_GPIO-1:0] w_in_s;
    logic              w_warm_done;
    logic [N_GPIO-1:0] w_match;
    logic [N_GPIO-1:0] w_edge;
    logic [N_GPIO-1:0] w_detect;
    logic [N_GPIO-1:0] w_stat_clr;
    logic [31:0]       w_rd_val;
    logic              w_unused;

    assign w_word  = addr[7:2];
    assign w_wdata = wdata[N_GPIO-1:0];

    // Byte-offset bits and wdata bits above N_GPIO carry no meaning.
    assign w_unused = &{1'b0, addr[1:0], wdata};

    // ------------------------------------------------------------------------
    // Input synchroniser, previous-value flop and warm-up counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
            r_warm <= '0;
        end else begin
            r_sync[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_in_s;
            if (r_warm != c_warm_last) begin
                r_warm <= r_warm + 3'd1;
            end
        end
    end

    assign w_in_s      = r_sync[SYNC_STAGES-1];
    assign w_warm_done = (r_warm == c_warm_last);

    // ------------------------------------------------------------------------
    // Interrupt detection
    // ------------------------------------------------------------------------
    // A pin "matches" when its synchronised level equals the polarity bit.
    // Edge mode additionally needs a change since last cycle, and is held off
    // during warm-up so pins already high at reset do not look like an edge.
    assign w_match  = ~(w_in_s ^ r_irq_pol);
    assign w_edge   = (w_in_s ^ r_prev) & w_match & {N_GPIO{w_warm_done}};
    assign w_detect = (r_irq_type & w_edge) | (~r_irq_type & w_match);

    assign w_stat_clr = (wr_en && (w_word == c_addr_stat)) ? w_wdata : '0;

    // ------------------------------------------------------------------------
    // Register file writes
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data     <= '0;
            r_dir      <= '0;
            r_irq_en   <= '0;
            r_irq_type <= '0;
            r_irq_pol  <= '0;
            r_stat     <= '0;
        end else begin
            if (wr_en) begin
                case (w_word)
                    c_addr_data: r_data     <= w_wdata;
                    c_addr_dir:  r_dir      <= w_wdata;
                    c_addr_set:  r_data     <= r_data | w_wdata;
                    c_addr_clr:  r_data     <= r_data & ~w_wdata;
                    c_addr_tgl:  r_data     <= r_data ^ w_wdata;
                    c_addr_en:   r_irq_en   <= w_wdata;
                    c_addr_type: r_irq_type <= w_wdata;
                    c_addr_pol:  r_irq_pol  <= w_wdata;
                    default:     ;
                endcase
            end
            // New detection takes priority over a coincident clear.
            r_stat <= (r_stat & ~w_stat_clr) | w_detect;
        end
    end

    // ------------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------------
    always_comb begin
        w_rd_val = '0;
        case (w_word)
            c_addr_data: w_rd_val[N_GPIO-1:0] = r_data;
            c_addr_dir:  w_rd_val[N_GPIO-1:0] = r_dir;
            c_addr_in:   w_rd_val[N_GPIO-1:0] = w_in_s;
            c_addr_en:   w_rd_val[N_GPIO-1:0] = r_irq_en;
            c_addr_type: w_rd_val[N_GPIO-1:0] = r_irq_type;
            c_addr_pol:  w_rd_val[N_GPIO-1:0] = r_irq_pol;
            c_addr_stat: w_rd_val[N_GPIO-1:0] = r_stat;
            default:     w_rd_val = '0;
        endcase
    end

    // Read data is captured from pre-write register values, so a same-cycle
    // write and read returns the old contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_en;
            if (rd_en) begin
                rdata <= w_rd_val;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign gpio_out = r_data & r_dir;
    assign gpio_oe  = r_dir;
    assign irq      = |(r_stat & r_irq_en);

endmodule

`default_nettype wire
